// File: rtl/ram_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_seq_ctrl_if
//  Description : Bundle of request inputs and RAM/counter control outputs for
//                the RAM snapshot sequencer.
//                master : request source (drives requests and tick1Hz)
//                slave  : sequencer (drives RAM/counter controls and status)
//                Requests : tick1Hz, save_req, load_req, load_slot, clear
//                Controls : address, wren, rden, LOAD_N
//                Status   : busy, err, wr_ptr, full
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_seq_ctrl_if #(
    parameter int AW = 4
);
    logic          tick1Hz;
    logic          save_req;
    logic          load_req;
    logic [AW-1:0] load_slot;
    logic          clear;
    logic [AW-1:0] address;
    logic          wren;
    logic          rden;
    logic          LOAD_N;
    logic          busy;
    logic          err;
    logic [AW-1:0] wr_ptr;
    logic          full;

    modport master (
        output tick1Hz, save_req, load_req, load_slot, clear,
        input  address, wren, rden, LOAD_N, busy, err, wr_ptr, full
    );

    modport slave (
        input  tick1Hz, save_req, load_req, load_slot, clear,
        output address, wren, rden, LOAD_N, busy, err, wr_ptr, full
    );
endinterface
`default_nettype wire

// File: rtl/ram_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_seq_ctrl
//  Description : Sequencer for a DEPTH x 8 snapshot RAM and the counter load.
//                Accepts one-deep save/load/clear requests, runs single-cycle
//                RAM writes into a ring of slots, and for loads reads a slot
//                and holds LOAD_N low until the slow counter clock samples it.
//  Ports       : clk   - RAM clock, all logic on rising edge
//                Reset - synchronous active-high reset
//                bus   - ram_seq_ctrl_if slave (requests in, controls out)
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_seq_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  wire logic      clk,
    input  wire logic      Reset,
    ram_seq_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_RDWAIT = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_d;

    logic             r_sv_pend;
    logic             r_ld_pend;
    logic             r_clr_pend;
    logic [AW-1:0]    r_ld_addr;
    logic [AW-1:0]    r_wr_ptr;
    logic [DEPTH-1:0] r_valid;

    logic [AW-1:0]    r_address;
    logic             r_wren;
    logic             r_rden;
    logic             r_load_n;
    logic             r_busy;
    logic             r_err;
    logic             r_full;

    logic             w_idle;
    logic             w_ld_bad;
    logic             w_sv_drop;
    logic             w_ld_drop;
    logic             w_clr_now;
    logic             w_clr_apply;
    logic             w_sv_pend_d;
    logic             w_ld_pend_d;
    logic             w_clr_pend_d;
    logic [DEPTH-1:0] w_valid_d;
    logic [AW-1:0]    w_wr_ptr_d;
    logic [AW-1:0]    w_address_d;
    logic             w_wren_d;
    logic             w_rden_d;
    logic             w_load_n_d;
    logic             w_busy_d;
    logic             w_err_d;

    // ------------------------------------------------------------------
    // Request bookkeeping: pending flags, slot valid map, ring pointer
    // ------------------------------------------------------------------
    always_comb begin
        w_idle    = (r_state == S_IDLE);
        // A queued load whose slot was never written is rejected in IDLE,
        // but only once any queued clear and save have been dealt with.
        w_ld_bad  = w_idle && !r_clr_pend && !r_sv_pend && r_ld_pend
                    && !r_valid[r_ld_addr];
        w_sv_drop = bus.save_req && r_sv_pend;
        w_ld_drop = bus.load_req && r_ld_pend;

        // Clear acts at once only when nothing is outstanding; otherwise it
        // waits for the next IDLE cycle so in-flight accesses see old state.
        w_clr_now   = bus.clear && w_idle && !r_sv_pend && !r_ld_pend && !r_clr_pend;
        w_clr_apply = w_clr_now || (w_idle && r_clr_pend);

        w_sv_pend_d  = (r_sv_pend && (r_state != S_WRITE)) || (bus.save_req && !r_sv_pend);
        w_ld_pend_d  = (r_ld_pend && !((r_state == S_HOLD) && bus.tick1Hz) && !w_ld_bad)
                       || (bus.load_req && !r_ld_pend);
        w_clr_pend_d = (bus.clear && !w_clr_now) || (r_clr_pend && !w_idle);

        w_valid_d  = r_valid;
        w_wr_ptr_d = r_wr_ptr;
        if (w_clr_apply) begin
            w_valid_d  = '0;
            w_wr_ptr_d = '0;
        end else if (r_state == S_WRITE) begin
            w_valid_d[r_wr_ptr] = 1'b1;
            // DEPTH is a power of two, so natural overflow gives the ring wrap
            w_wr_ptr_d          = r_wr_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE: begin
                // A deferred clear gets this IDLE cycle to itself
                if (r_clr_pend) begin
                    w_state_d = S_IDLE;
                end else if (r_sv_pend) begin
                    w_state_d = S_WRITE;
                end else if (r_ld_pend && r_valid[r_ld_addr]) begin
                    w_state_d = S_READ;
                end
            end
            S_WRITE:  w_state_d = S_IDLE;
            S_READ:   w_state_d = S_RDWAIT;
            S_RDWAIT: w_state_d = S_HOLD;
            S_HOLD: begin
                if (bus.tick1Hz) begin
                    w_state_d = S_IDLE;
                end
            end
            default:  w_state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic, evaluated on the next state so that every output
    // is a flop that lines up with the state it belongs to
    // ------------------------------------------------------------------
    always_comb begin
        w_wren_d    = (w_state_d == S_WRITE);
        w_rden_d    = (w_state_d == S_READ);
        w_load_n_d  = (w_state_d != S_HOLD);
        w_address_d = r_address;
        case (w_state_d)
            S_WRITE:                  w_address_d = r_wr_ptr;
            S_READ, S_RDWAIT, S_HOLD: w_address_d = r_ld_addr;
            default:                  w_address_d = r_address;
        endcase
        w_busy_d = (w_state_d != S_IDLE) || w_sv_pend_d || w_ld_pend_d || w_clr_pend_d;
        w_err_d  = w_sv_drop || w_ld_drop || w_ld_bad;
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_sv_pend  <= 1'b0;
            r_ld_pend  <= 1'b0;
            r_clr_pend <= 1'b0;
            r_ld_addr  <= '0;
            r_wr_ptr   <= '0;
            r_valid    <= '0;
            r_address  <= '0;
            r_wren     <= 1'b0;
            r_rden     <= 1'b0;
            r_load_n   <= 1'b1;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_sv_pend  <= w_sv_pend_d;
            r_ld_pend  <= w_ld_pend_d;
            r_clr_pend <= w_clr_pend_d;
            if (bus.load_req && !r_ld_pend) begin
                r_ld_addr <= bus.load_slot;
            end
            r_wr_ptr   <= w_wr_ptr_d;
            r_valid    <= w_valid_d;
            r_address  <= w_address_d;
            r_wren     <= w_wren_d;
            r_rden     <= w_rden_d;
            r_load_n   <= w_load_n_d;
            r_busy     <= w_busy_d;
            r_err      <= w_err_d;
            r_full     <= &w_valid_d;
        end
    end

    assign bus.address = r_address;
    assign bus.wren    = r_wren;
    assign bus.rden    = r_rden;
    assign bus.LOAD_N  = r_load_n;
    assign bus.busy    = r_busy;
    assign bus.err     = r_err;
    assign bus.wr_ptr  = r_wr_ptr;
    assign bus.full    = r_full;

endmodule
`default_nettype wire
